// File: rtl/bus_sync_filter.sv
// Multi-bit level synchronizer with optional per-channel persistence filter and edge pulses.
// Define BUS_SYNC_GLITCH_FILTER_EN to compile in the FILT_CYCLES glitch filter.

module bus_sync_filter_lane #(
  parameter int NUM_STAGES  = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_o
);
  if (NUM_STAGES < 2 || NUM_STAGES > 8 || FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_cfg
    $error("bus_sync_filter: NUM_STAGES or FILT_CYCLES out of range");
  end

  logic [NUM_STAGES-1:0] chain_q;
  logic                  s;
  logic                  sync_q, sync_d;
  logic                  rise_q, fall_q;

  assign s = chain_q[NUM_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) chain_q <= '0;
    else         chain_q <= {chain_q[NUM_STAGES-2:0], async_i};
  end

`ifdef BUS_SYNC_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A differing level must be seen FILT_CYCLES edges in a row; any agreement restarts the count.
  always_comb begin
    cnt_d  = '0;
    sync_d = sync_q;
    if (s != sync_q) begin
      if (cnt_q == CNT_LAST) sync_d = s;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign sync_d = s;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= sync_d & ~sync_q;
      fall_q <= ~sync_d & sync_q;
    end
  end

  // Unregistered change flag so the top can register the OR in the same cycle as the pulses.
  assign edge_o = sync_d ^ sync_q;
  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

module bus_sync_filter #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 4,
  parameter int FILT_CYCLES = 4
) (
  input  logic                 CLK_destination,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] async,
  output logic [BUS_WIDTH-1:0] sync,
  output logic [BUS_WIDTH-1:0] rise,
  output logic [BUS_WIDTH-1:0] fall,
  output logic                 changed
);
  if (BUS_WIDTH < 1 || BUS_WIDTH > 32) begin : g_bad_width
    $error("bus_sync_filter: BUS_WIDTH out of range");
  end

  logic [BUS_WIDTH-1:0] edge_d;
  logic                 changed_q;

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_lane
    bus_sync_filter_lane #(
      .NUM_STAGES (NUM_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_lane (
      .clk_i  (CLK_destination),
      .rst_ni (RST),
      .async_i(async[i]),
      .sync_o (sync[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i]),
      .edge_o (edge_d[i])
    );
  end

  always_ff @(posedge CLK_destination or negedge RST) begin
    if (!RST) changed_q <= 1'b0;
    else      changed_q <= |edge_d;
  end

  assign changed = changed_q;
endmodule

// File: tb/tb_bus_sync_filter.sv
// Directed bench for bus_sync_filter; expectations follow whichever filter build is compiled.
module tb_bus_sync_filter;
  localparam int NS = 2;
  localparam int BW = 4;
  localparam int FC = 4;
`ifdef BUS_SYNC_GLITCH_FILTER_EN
  localparam int FE = 1;
`else
  localparam int FE = 0;
`endif
  localparam int LAT = FE ? NS + FC : NS + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] async_in = '0;
  logic [BW-1:0] sync_out, rise_out, fall_out;
  logic          changed_out;
  int            nchk = 0;
  int            nerr = 0;

  bus_sync_filter #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .FILT_CYCLES(FC)) dut (
    .CLK_destination(clk),
    .RST            (rst_n),
    .async          (async_in),
    .sync           (sync_out),
    .rise           (rise_out),
    .fall           (fall_out),
    .changed        (changed_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [BW-1:0] s, input logic [BW-1:0] r,
                         input logic [BW-1:0] f, input logic c);
    chk({tag, ".sync"}, 32'(sync_out), 32'(s));
    chk({tag, ".rise"}, 32'(rise_out), 32'(r));
    chk({tag, ".fall"}, 32'(fall_out), 32'(f));
    chk({tag, ".changed"}, 32'(changed_out), 32'(c));
  endtask

  // Whole-bus level change from settled old to new; output moves exactly LAT edges later.
  task automatic trans(input string tag, input logic [BW-1:0] old_v, input logic [BW-1:0] new_v);
    async_in = new_v;
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      if (e < LAT)       chk_all(tag, old_v, '0, '0, 1'b0);
      else if (e == LAT) chk_all(tag, new_v, new_v & ~old_v, old_v & ~new_v, new_v != old_v);
      else               chk_all(tag, new_v, '0, '0, 1'b0);
    end
  endtask

  // Bit b high for p source cycles from an all-zero settled state.
  task automatic pulse(input string tag, input int b, input int p);
    logic pass;
    logic [BW-1:0] one;
    pass = (FE == 0) || (p >= FC);
    one  = BW'(1) << b;
    async_in = one;
    for (int e = 1; e <= LAT + p + 2; e++) begin
      step();
      if (e == p) async_in = '0;
      chk_all(tag,
              (pass && e >= LAT && e <= LAT + p - 1) ? one : '0,
              (pass && e == LAT)     ? one : '0,
              (pass && e == LAT + p) ? one : '0,
              pass && (e == LAT || e == LAT + p));
    end
  endtask

  initial begin
    async_in = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset_hold", '0, '0, '0, 1'b0);
    end

    async_in = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("release_quiet", '0, '0, '0, 1'b0);
    end

    trans("t_0_5", 4'h0, 4'h5);
    trans("t_5_A", 4'h5, 4'hA);
    trans("t_A_0", 4'hA, 4'h0);

    pulse("glitch3_b0", 0, 3);
    pulse("hold4_b0", 0, 4);
    pulse("glitch1_b3", 3, 1);
    pulse("hold6_b2", 2, 6);

    trans("t_0_8", 4'h0, 4'h8);

    // Reset asserted mid-count must clear everything without waiting for a clock.
    async_in = 4'h9;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk_all("async_clear", '0, '0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("reset_mid", '0, '0, '0, 1'b0);
    end
    rst_n = 1'b1;
    trans("restart_9", 4'h0, 4'h9);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
